// File: rtl/div_r32m.sv
// div_r32m: multi-cycle restoring integer divider (DIV/DIVU/REM/REMU).
//
// One shift-subtract step per clock on absolute operand values; signs are
// restored when the result is written. Divide-by-zero and signed overflow
// results are decided when the operands are accepted.
//
// Optional feature macro: DIV_EARLY_OUT_EN. When defined, divide-by-zero and
// signed-overflow requests skip the iteration phase and go straight to DONE.
//
// Ports:
//   clk      - clock, rising edge
//   nReset   - asynchronous active-low reset
//   start    - request a division, sampled only while idle
//   divCode  - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend - numerator (dataW bits)
//   divisor  - denominator (dataW bits)
//   busy     - high while iterating
//   done     - one-cycle pulse, out valid
//   out      - registered quotient or remainder
module div_r32m #(
  parameter int unsigned dataW = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [1:0]       divCode,
  input  logic [dataW-1:0] dividend,
  input  logic [dataW-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [dataW-1:0] out
);

  localparam int unsigned CntW = $clog2(dataW + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(dataW - 1);
  localparam logic [dataW-1:0] MinVal = {1'b1, {(dataW - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [dataW-1:0]  rem_q, rem_d;
  logic [dataW-1:0]  quo_q, quo_d;
  logic [dataW-1:0]  dvs_q, dvs_d;
  logic              is_rem_q, is_rem_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              spec_q, spec_d;
  logic [dataW-1:0]  spec_res_q, spec_res_d;
  logic [dataW-1:0]  out_q, out_d;

  // Operand decode for the request presented at the inputs.
  logic             in_signed, dvd_neg, dvs_neg, in_zero, in_ovf, in_spec;
  logic [dataW-1:0] in_spec_res, dvd_abs, dvs_abs;

  // One restoring step on the current working registers.
  logic [dataW:0]   shifted, trial;
  logic [dataW-1:0] rem_step, quo_step, q_fix, r_fix, calc_res;

  always_comb begin
    in_signed = ~divCode[0];
    dvd_neg   = in_signed & dividend[dataW-1];
    dvs_neg   = in_signed & divisor[dataW-1];
    dvd_abs   = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_abs   = dvs_neg ? (~divisor + 1'b1) : divisor;
    in_zero   = (divisor == '0);
    in_ovf    = in_signed & (dividend == MinVal) & (divisor == '1);
    in_spec   = in_zero | in_ovf;
    // Overflow quotient equals the dividend (MinVal); remainder is zero.
    if (divCode[1]) begin
      in_spec_res = in_zero ? dividend : '0;
    end else begin
      in_spec_res = in_zero ? '1 : dividend;
    end
  end

  always_comb begin
    shifted = {rem_q, quo_q[dataW-1]};
    trial   = shifted - {1'b0, dvs_q};
    // Bit dataW of the trial difference set means the subtraction underflowed.
    if (!trial[dataW]) begin
      rem_step = trial[dataW-1:0];
      quo_step = {quo_q[dataW-2:0], 1'b1};
    end else begin
      rem_step = shifted[dataW-1:0];
      quo_step = {quo_q[dataW-2:0], 1'b0};
    end
    q_fix    = qneg_q ? (~quo_step + 1'b1) : quo_step;
    r_fix    = rneg_q ? (~rem_step + 1'b1) : rem_step;
    calc_res = spec_q ? spec_res_q : (is_rem_q ? r_fix : q_fix);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    is_rem_d   = is_rem_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    out_d      = out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d      = '0;
          rem_d      = '0;
          quo_d      = dvd_abs;
          dvs_d      = dvs_abs;
          is_rem_d   = divCode[1];
          qneg_d     = dvd_neg ^ dvs_neg;
          rneg_d     = dvd_neg;
          spec_d     = in_spec;
          spec_res_d = in_spec_res;
`ifdef DIV_EARLY_OUT_EN
          if (in_spec) begin
            state_d = StDone;
            out_d   = in_spec_res;
          end else begin
            state_d = StCalc;
          end
`else
          state_d = StCalc;
`endif
        end
      end
      StCalc: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          out_d   = calc_res;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      is_rem_q   <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      is_rem_q   <= is_rem_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      out_q      <= out_d;
    end
  end

  assign busy = (state_q == StCalc);
  assign done = (state_q == StDone);
  assign out  = out_q;

endmodule
